// File: rtl/lsu.sv
// ============================================================================
// lsu : load/store unit with request/ready memory handshake and timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu #(
  parameter int WORD    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            memRead,
  input  logic            memWrite,
  input  logic [2:0]      funct3,
  input  logic [WORD-1:0] addr,
  input  logic [WORD-1:0] writeData,
  output logic [WORD-1:0] readData,
  output logic            stall,
  output logic            misaligned,
  output logic            busErr,
  output logic            mem_req,
  output logic            mem_we,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ready,
  input  logic [WORD-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int         CW     = $clog2(TIMEOUT + 1);

  logic [1:0]      state_q,  state_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic [WORD-1:0] addr_q,   addr_d;
  logic            we_q,     we_d;
  logic [WORD-1:0] wdata_q,  wdata_d;
  logic [3:0]      be_q,     be_d;
  logic [2:0]      f3_q,     f3_d;
  logic [1:0]      off_q,    off_d;
  logic [WORD-1:0] rdata_q,  rdata_d;
  logic            buserr_q, buserr_d;

  logic            idle, busy, access, legal, aligned, start;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [WORD-1:0] load_val;

  assign idle   = (state_q == S_IDLE);
  assign busy   = (state_q == S_BUSY);
  assign access = memRead | memWrite;

  // BU/HU only exist for loads; a store wins when both strobes are high
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b1;
    case (funct3)
      3'b000, 3'b010: legal = 1'b1;
      3'b001:         legal = 1'b1;
      3'b100, 3'b101: legal = ~memWrite;
      default:        legal = 1'b0;
    endcase
    if (funct3[1:0] == 2'b01)      aligned = ~addr[0];
    else if (funct3 == 3'b010)     aligned = (addr[1:0] == 2'b00);
  end

  assign start = idle & access & legal & aligned;

  always_comb begin
    rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
    rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_val = {{(WORD-8){rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{(WORD-16){rd_half[15]}}, rd_half};
      3'b100:  load_val = {{(WORD-8){1'b0}}, rd_byte};
      3'b101:  load_val = {{(WORD-16){1'b0}}, rd_half};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    f3_d     = f3_q;
    off_d    = off_q;
    rdata_d  = rdata_q;
    buserr_d = buserr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_BUSY;
          cnt_d    = '0;
          addr_d   = {addr[WORD-1:2], 2'b00};
          we_d     = memWrite;
          f3_d     = funct3;
          off_d    = addr[1:0];
          rdata_d  = '0;
          buserr_d = 1'b0;
          wdata_d  = '0;
          be_d     = 4'b0000;
          if (memWrite) begin
            case (funct3[1:0])
              2'b00: begin
                wdata_d = {(WORD/8){writeData[7:0]}};
                be_d    = 4'b0001 << addr[1:0];
              end
              2'b01: begin
                wdata_d = {(WORD/16){writeData[15:0]}};
                be_d    = addr[1] ? 4'b1100 : 4'b0011;
              end
              default: begin
                wdata_d = writeData;
                be_d    = 4'b1111;
              end
            endcase
          end
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          state_d = S_DONE;
          rdata_d = we_q ? '0 : load_val;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d  = S_DONE;
          rdata_d  = '0;
          buserr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= 4'b0000;
      f3_q     <= 3'b000;
      off_q    <= 2'b00;
      rdata_q  <= '0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      rdata_q  <= rdata_d;
      buserr_q <= buserr_d;
    end
  end

  // Outputs are gated by reset so an asserted reset silences the stall at once
  assign stall      = reset & (busy | start);
  assign misaligned = reset & idle & access & ~(legal & aligned);
  assign busErr     = (state_q == S_DONE) & buserr_q;
  assign readData   = (state_q == S_DONE) ? rdata_q : '0;
  assign mem_req    = busy;
  assign mem_we     = busy & we_q;
  assign mem_addr   = busy ? addr_q  : '0;
  assign mem_wdata  = busy ? wdata_q : '0;
  assign mem_be     = busy ? be_q    : 4'b0000;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
// tb_lsu : table-driven and sequence checks for lsu
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lsu;

  logic        clk;
  logic        reset;
  logic        memRead, memWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, writeData, readData;
  logic        stall, misaligned, busErr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ready;

  int n_pass  = 0;
  int n_total = 0;

  lsu #(.WORD(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .funct3(funct3), .addr(addr), .writeData(writeData), .readData(readData),
    .stall(stall), .misaligned(misaligned), .busErr(busErr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic        we;
    logic [31:0] eaddr;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    memRead   = 1'b0;
    memWrite  = 1'b0;
    funct3    = 3'b111;
    addr      = 32'hFFFF_FFF3;
    writeData = 32'h5A5A_5A5A;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag       = $sformatf("v%0d", idx);
    memRead   = v.rd;
    memWrite  = v.wr;
    funct3    = v.f3;
    addr      = v.a;
    writeData = v.wd;
    @(negedge clk);
    check({tag, ".stall_idle"}, 32'(stall), 32'(!v.mis));
    check({tag, ".mis"}, 32'(misaligned), 32'(v.mis));
    check({tag, ".req_idle"}, 32'(mem_req), 32'd0);
    if (v.mis) begin
      check({tag, ".rd_mis"}, readData, 32'd0);
      next_edge();
      idle_inputs();
      @(negedge clk);
      check({tag, ".req_after_mis"}, 32'(mem_req), 32'd0);
      check({tag, ".mis_pulse"}, 32'(misaligned), 32'd0);
      return;
    end
    next_edge();
    idle_inputs();
    mem_ready = 1'b1;
    mem_rdata = v.rdata;
    @(negedge clk);
    check({tag, ".req"}, 32'(mem_req), 32'd1);
    check({tag, ".stall_busy"}, 32'(stall), 32'd1);
    check({tag, ".addr"}, mem_addr, v.eaddr);
    check({tag, ".be"}, 32'(mem_be), 32'(v.be));
    check({tag, ".we"}, 32'(mem_we), 32'(v.we));
    if (v.we) check({tag, ".wdata"}, mem_wdata, v.ewd);
    next_edge();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    @(negedge clk);
    check({tag, ".stall_done"}, 32'(stall), 32'd0);
    check({tag, ".rdata"}, readData, v.erd);
    check({tag, ".buserr"}, 32'(busErr), 32'd0);
    next_edge();
    @(negedge clk);
    check({tag, ".req_end"}, 32'(mem_req), 32'd0);
  endtask

  // ready_cycle = 0 means mem_ready never arrives
  task automatic run_wait(input int ready_cycle, input logic [31:0] rdata,
                          input logic exp_err, input logic [31:0] exp_rd);
    int n_busy;
    n_busy    = (ready_cycle == 0) ? 4 : ready_cycle;
    memRead   = 1'b1;
    memWrite  = 1'b0;
    funct3    = 3'b010;
    addr      = 32'h0000_0040;
    @(negedge clk);
    check("wait.stall_idle", 32'(stall), 32'd1);
    for (int i = 1; i <= n_busy; i++) begin
      next_edge();
      idle_inputs();
      addr = 32'h1000_0000 + 32'(i);
      if (i == ready_cycle) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clk);
      check($sformatf("wait.req_c%0d", i), 32'(mem_req), 32'd1);
      check($sformatf("wait.stall_c%0d", i), 32'(stall), 32'd1);
      check($sformatf("wait.addr_c%0d", i), mem_addr, 32'h40);
    end
    next_edge();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    @(negedge clk);
    check("wait.buserr", 32'(busErr), 32'(exp_err));
    check("wait.rdata", readData, exp_rd);
    check("wait.stall_done", 32'(stall), 32'd0);
    check("wait.mis_done", 32'(misaligned), 32'd0);
    next_edge();
    @(negedge clk);
    check("wait.buserr_pulse", 32'(busErr), 32'd0);
    check("wait.req_end", 32'(mem_req), 32'd0);
  endtask

  initial begin
    //            rd wr  f3      addr         wd            rdata        mis be       ewd           we eaddr        erd
    vecs[0]  = '{1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 4'b0000, 32'h0,        0, 32'h100, 32'hDEADBEEF};
    vecs[1]  = '{1, 0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 0, 4'b0000, 32'h0,        0, 32'h100, 32'hFFFFFF80};
    vecs[2]  = '{1, 0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 0, 4'b0000, 32'h0,        0, 32'h100, 32'h00000080};
    vecs[3]  = '{1, 0, 3'b001, 32'h102, 32'h0,        32'h80FF0000, 0, 4'b0000, 32'h0,        0, 32'h100, 32'hFFFF80FF};
    vecs[4]  = '{1, 0, 3'b101, 32'h102, 32'h0,        32'h80FF0000, 0, 4'b0000, 32'h0,        0, 32'h100, 32'h000080FF};
    vecs[5]  = '{1, 0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 0, 4'b0000, 32'h0,        0, 32'h100, 32'h0000007F};
    vecs[6]  = '{1, 0, 3'b001, 32'h100, 32'h0,        32'h12348001, 0, 4'b0000, 32'h0,        0, 32'h100, 32'hFFFF8001};
    vecs[7]  = '{0, 1, 3'b000, 32'h102, 32'h123456AB, 32'hFFFFFFFF, 0, 4'b0100, 32'hABABABAB, 1, 32'h100, 32'h0};
    vecs[8]  = '{0, 1, 3'b001, 32'h102, 32'h123456AB, 32'hFFFFFFFF, 0, 4'b1100, 32'h56AB56AB, 1, 32'h100, 32'h0};
    vecs[9]  = '{0, 1, 3'b001, 32'h200, 32'h0000BEEF, 32'h0,        0, 4'b0011, 32'hBEEFBEEF, 1, 32'h200, 32'h0};
    vecs[10] = '{0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0,        0, 4'b1111, 32'hCAFEF00D, 1, 32'h204, 32'h0};
    vecs[11] = '{0, 1, 3'b000, 32'h001, 32'h12345699, 32'h0,        0, 4'b0010, 32'h99999999, 1, 32'h000, 32'h0};
    vecs[12] = '{1, 1, 3'b010, 32'h010, 32'h0A0B0C0D, 32'h55555555, 0, 4'b1111, 32'h0A0B0C0D, 1, 32'h010, 32'h0};
    vecs[13] = '{1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        0, 32'h0,   32'h0};
    vecs[14] = '{0, 1, 3'b001, 32'h001, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        0, 32'h0,   32'h0};
    vecs[15] = '{0, 1, 3'b100, 32'h100, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        0, 32'h0,   32'h0};
    vecs[16] = '{1, 0, 3'b011, 32'h100, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        0, 32'h0,   32'h0};
    vecs[17] = '{1, 0, 3'b001, 32'h103, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        0, 32'h0,   32'h0};
    vecs[18] = '{0, 1, 3'b010, 32'h102, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        0, 32'h0,   32'h0};

    reset     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    idle_inputs();
    memRead   = 1'b0;
    @(negedge clk);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.req", 32'(mem_req), 32'd0);
    check("rst.be", 32'(mem_be), 32'd0);
    check("rst.rdata", readData, 32'd0);
    check("rst.flags", {30'd0, busErr, misaligned}, 32'd0);
    next_edge();
    reset = 1'b1;
    @(negedge clk);
    check("noacc.stall", 32'(stall), 32'd0);
    check("noacc.req", 32'(mem_req), 32'd0);

    for (int i = 0; i < 19; i++) begin
      next_edge();
      run_vec(vecs[i], i);
    end

    next_edge();
    run_wait(0, 32'h0, 1'b0 + 1'b1, 32'h0);
    next_edge();
    run_wait(4, 32'h12345678, 1'b0, 32'h12345678);
    next_edge();
    run_wait(2, 32'h0BADF00D, 1'b0, 32'h0BADF00D);

    // Reset dropped during the second BUSY cycle
    next_edge();
    memRead = 1'b1;
    funct3  = 3'b010;
    addr    = 32'h100;
    next_edge();
    idle_inputs();
    next_edge();
    #2;
    check("arst.req_before", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    check("arst.req", 32'(mem_req), 32'd0);
    check("arst.stall", 32'(stall), 32'd0);
    next_edge();
    reset = 1'b1;
    @(negedge clk);
    check("arst.req_after", 32'(mem_req), 32'd0);
    check("arst.rdata_after", readData, 32'd0);
    next_edge();
    run_vec(vecs[0], 100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
